word_uart_tx: RTL and testbench

Serial transmitter for 16-bit words over an 8N1 UART link, sending each word as two frames: low byte first, then high byte, each LSB first. It is the transmit counterpart of the FRANK6000 16-bit instruction receive path, used to send instruction or result words to a host or another FRANK6000 board. A one-entry holding buffer lets the next word be accepted while the current word is still shifting, so consecutive words go out back-to-back.

---
 rtl/word_uart_tx.sv | 151 +++++++++++++++
 tb/tb_word_uart_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_uart_tx.sv
// ============================================================================
// Module      : word_uart_tx
// Description : 8N1 UART transmitter for 16-bit words (low byte first) with a
//               one-entry holding buffer for back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tx_dv,
  input  logic [15:0] i_tx_word,
  output logic        o_tx_ready,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_tx_done,
  output logic        o_tx_overrun
);

  localparam logic [15:0] C_LAST_CLK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [15:0] r_clk_cnt,  w_clk_cnt_nxt;
  logic [2:0]  r_bit_idx,  w_bit_idx_nxt;
  logic        r_byte_sel, w_byte_sel_nxt;
  logic [15:0] r_shift,    w_shift_nxt;
  logic [15:0] r_hold,     w_hold_nxt;
  logic        r_full,     w_full_nxt;
  logic        r_done,     w_done_nxt;
  logic        r_overrun,  w_overrun_nxt;
  logic        w_bit_end;
  logic        w_load;

  assign w_bit_end = (r_clk_cnt == C_LAST_CLK);

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = r_clk_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_sel_nxt = r_byte_sel;
    w_shift_nxt    = r_shift;
    w_hold_nxt     = r_hold;
    w_full_nxt     = r_full;
    w_done_nxt     = 1'b0;
    w_overrun_nxt  = i_tx_dv && r_full;
    w_load         = 1'b0;

    if (r_state != S_IDLE) begin
      w_clk_cnt_nxt = w_bit_end ? 16'd0 : r_clk_cnt + 16'd1;
    end

    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = 16'd0;
        w_load        = r_full;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!r_byte_sel) begin
            w_byte_sel_nxt = 1'b1;
            w_state_nxt    = S_START;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            w_load      = r_full;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A load frees the holding slot; a same-edge capture refills it below.
    if (w_load) begin
      w_state_nxt    = S_START;
      w_clk_cnt_nxt  = 16'd0;
      w_byte_sel_nxt = 1'b0;
      w_shift_nxt    = r_hold;
      w_full_nxt     = 1'b0;
    end

    if (i_tx_dv && !r_full) begin
      w_hold_nxt = i_tx_word;
      w_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_byte_sel <= 1'b0;
      r_shift    <= 16'd0;
      r_hold     <= 16'd0;
      r_full     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_shift    <= w_shift_nxt;
      r_hold     <= w_hold_nxt;
      r_full     <= w_full_nxt;
      r_done     <= w_done_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  always_comb begin
    case (r_state)
      S_START: o_tx_serial = 1'b0;
      S_DATA:  o_tx_serial = r_shift[{r_byte_sel, r_bit_idx}];
      default: o_tx_serial = 1'b1;
    endcase
  end

  assign o_tx_ready   = !r_full;
  assign o_tx_active  = (r_state != S_IDLE);
  assign o_tx_done    = r_done;
  assign o_tx_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_word_uart_tx.sv
// ============================================================================
// Module      : tb_word_uart_tx
// Description : Self-checking bench for word_uart_tx: cycle-exact waveforms,
//               back-to-back, overrun, mid-frame reset and UART loopback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [15:0] word = 16'd0;
  logic [1:0]  sel = 2'd0;
  int          rx_cpb = 4;
  bit          rx_en = 1'b1;
  bit          rx_have_lo = 1'b0;
  logic [7:0]  rx_lo;

  logic [2:0] s_ready, s_serial, s_active, s_done, s_ovr;
  logic       m_ready, m_serial, m_active, m_done, m_ovr;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  word_uart_tx #(.CLKS_PER_BIT(4)) u_tx4 (
    .i_clk(clk), .i_rst(rst), .i_tx_dv(dv && sel == 2'd0), .i_tx_word(word),
    .o_tx_ready(s_ready[0]), .o_tx_serial(s_serial[0]), .o_tx_active(s_active[0]),
    .o_tx_done(s_done[0]), .o_tx_overrun(s_ovr[0]));

  word_uart_tx #(.CLKS_PER_BIT(217)) u_tx217 (
    .i_clk(clk), .i_rst(rst), .i_tx_dv(dv && sel == 2'd1), .i_tx_word(word),
    .o_tx_ready(s_ready[1]), .o_tx_serial(s_serial[1]), .o_tx_active(s_active[1]),
    .o_tx_done(s_done[1]), .o_tx_overrun(s_ovr[1]));

  word_uart_tx #(.CLKS_PER_BIT(2)) u_tx2 (
    .i_clk(clk), .i_rst(rst), .i_tx_dv(dv && sel == 2'd2), .i_tx_word(word),
    .o_tx_ready(s_ready[2]), .o_tx_serial(s_serial[2]), .o_tx_active(s_active[2]),
    .o_tx_done(s_done[2]), .o_tx_overrun(s_ovr[2]));

  always_comb begin
    case (sel)
      2'd1:    begin m_ready = s_ready[1]; m_serial = s_serial[1]; m_active = s_active[1]; m_done = s_done[1]; m_ovr = s_ovr[1]; end
      2'd2:    begin m_ready = s_ready[2]; m_serial = s_serial[2]; m_active = s_active[2]; m_done = s_done[2]; m_ovr = s_ovr[2]; end
      default: begin m_ready = s_ready[0]; m_serial = s_serial[0]; m_active = s_active[0]; m_done = s_done[0]; m_ovr = s_ovr[0]; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h @%0t", tag, act, exp, $time);
    end
  endtask

  // Present one word for a single sampling edge; returns at the following negedge.
  task automatic send(input logic [15:0] w, input bit expect_tx);
    dv   = 1'b1;
    word = w;
    if (expect_tx) sb_q.push_back(w);
    @(negedge clk);
    dv = 1'b0;
  endtask

  // Called at the negedge of the first start-bit cycle; returns 20*cpb cycles later.
  task automatic check_wave(input string tag, input logic [15:0] w, input int cpb);
    logic [9:0] fr;
    int nerr = 0;
    for (int b = 0; b < 2; b++) begin
      fr = {1'b1, w[b*8 +: 8], 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < cpb; c++) begin
          if (m_serial !== fr[k]) nerr++;
          if ((b != 0 || k != 0 || c != 0) && m_done !== 1'b0) nerr++;
          @(negedge clk);
        end
      end
    end
    chk(tag, nerr, 0);
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (m_ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", {31'd0, m_ready}, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (m_active !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, m_active}, 32'd0);
  endtask

  // Independent 8N1 receiver: samples mid-bit and pairs bytes low-then-high.
  initial begin
    logic [7:0]  b;
    logic [15:0] got;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rx_en && !rst && m_serial === 1'b0) begin
        repeat (rx_cpb / 2) @(negedge clk);
        chk("rx_start", {31'd0, m_serial}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (rx_cpb) @(negedge clk);
          b[i] = m_serial;
        end
        repeat (rx_cpb) @(negedge clk);
        chk("rx_stop", {31'd0, m_serial}, 32'd1);
        if (!rx_have_lo) begin
          rx_lo      = b;
          rx_have_lo = 1'b1;
        end else begin
          rx_have_lo = 1'b0;
          got = {b, rx_lo};
          exp = (sb_q.size() > 0) ? {16'd0, sb_q.pop_front()} : 32'hDEAD_0000;
          chk("rx_word", {16'd0, got}, exp);
        end
      end
    end
  end

  initial begin
    int cnt_done;
    int cnt_act;
    logic [15:0] rw;

    repeat (3) @(negedge clk);
    chk("rst_serial",  {31'd0, m_serial}, 32'd1);
    chk("rst_ready",   {31'd0, m_ready},  32'd1);
    chk("rst_active",  {31'd0, m_active}, 32'd0);
    chk("rst_done",    {31'd0, m_done},   32'd0);
    chk("rst_overrun", {31'd0, m_ovr},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word at CLKS_PER_BIT=4
    send(16'hA55A, 1'b1);
    chk("lat_ready_lo", {31'd0, m_ready},  32'd0);
    chk("lat_serial_hi", {31'd0, m_serial}, 32'd1);
    @(negedge clk);
    chk("lat_ready_hi", {31'd0, m_ready},  32'd1);
    chk("lat_active",   {31'd0, m_active}, 32'd1);
    check_wave("wave_A55A", 16'hA55A, 4);
    chk("done_A55A",  {31'd0, m_done},   32'd1);
    chk("idle_A55A",  {31'd0, m_active}, 32'd0);
    @(negedge clk);
    chk("done_pulse_end", {31'd0, m_done}, 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back
    send(16'h1234, 1'b1);
    chk("b2b_ready_lo", {31'd0, m_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_hi", {31'd0, m_ready}, 32'd1);
    dv   = 1'b1;
    word = 16'hFFFF;
    sb_q.push_back(16'hFFFF);
    fork
      check_wave("wave_1234", 16'h1234, 4);
      begin @(negedge clk); dv = 1'b0; end
    join
    chk("b2b_done1", {31'd0, m_done}, 32'd1);
    check_wave("wave_FFFF", 16'hFFFF, 4);
    chk("b2b_done2", {31'd0, m_done},   32'd1);
    chk("b2b_idle",  {31'd0, m_active}, 32'd0);
    repeat (4) @(negedge clk);

    // Overrun
    send(16'h0001, 1'b1);
    @(negedge clk);
    send(16'h0002, 1'b1);
    chk("ovr_full", {31'd0, m_ready}, 32'd0);
    dv   = 1'b1;
    word = 16'h0003;
    @(negedge clk);
    dv = 1'b0;
    chk("ovr_pulse", {31'd0, m_ovr},   32'd1);
    chk("ovr_still_full", {31'd0, m_ready}, 32'd0);
    @(negedge clk);
    chk("ovr_pulse_end", {31'd0, m_ovr}, 32'd0);
    wait_idle(400);
    repeat (4) @(negedge clk);
    chk("ovr_sb_empty", sb_q.size(), 0);

    // Reset during high-byte DATA bit 3, with a word waiting in the buffer
    rx_en = 1'b0;
    send(16'h0000, 1'b0);
    @(negedge clk);
    send(16'h0F0F, 1'b0);
    repeat (56) @(negedge clk);
    chk("mid_line_low", {31'd0, m_serial}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_serial", {31'd0, m_serial}, 32'd1);
    chk("mid_rst_ready",  {31'd0, m_ready},  32'd1);
    chk("mid_rst_active", {31'd0, m_active}, 32'd0);
    cnt_done = 0;
    cnt_act  = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_done !== 1'b0) cnt_done++;
      if (m_active !== 1'b0 || m_serial !== 1'b1) cnt_act++;
      @(negedge clk);
    end
    chk("mid_no_done", cnt_done, 0);
    chk("mid_stay_idle", cnt_act, 0);
    rx_have_lo = 1'b0;
    rx_en      = 1'b1;

    // Minimum CLKS_PER_BIT=2
    sel    = 2'd2;
    rx_cpb = 2;
    @(negedge clk);
    send(16'h8001, 1'b1);
    @(negedge clk);
    check_wave("wave_8001", 16'h8001, 2);
    chk("done_8001", {31'd0, m_done}, 32'd1);
    repeat (4) @(negedge clk);

    // Loopback at CLKS_PER_BIT=217
    sel    = 2'd1;
    rx_cpb = 217;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wait_ready(5000);
      rw = 16'($urandom);
      send(rw, 1'b1);
    end
    repeat (2) @(negedge clk);
    wait_idle(20000);
    repeat (4) @(negedge clk);
    chk("loop_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
